// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (IF) and data (MEM)
// requesters. Data has priority; a streak counter guarantees fetch progress.
// Optional feature: define ARB_TIMEOUT_EN to enable the REQ/RESP watchdog that
// raises a sticky arb_err and forces completion with zero read data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  // Fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  // Data requester
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  // Memory interface
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              arb_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = data requester owns the transaction
  logic                kill_q, kill_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;

  logic                dm_req;
  logic                fetch_win;
  logic                flush_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                arb_err_q, arb_err_d;
`endif

  assign dm_req    = dm_read | dm_write;
  assign fetch_win = if_req & (~dm_req | (streak_q == StreakMax));
  assign flush_hit = if_flush & ~owner_q & (state_q != StIdle);

  // Next-state, arbitration and capture logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q | flush_hit;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    arb_err_d   = arb_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (fetch_win) begin
          owner_d    = 1'b0;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          streak_d   = '0;
          mem_req_d  = 1'b1;
          state_d    = StReq;
        end else if (dm_req) begin
          owner_d     = 1'b1;
          mem_addr_d  = dm_addr;
          mem_we_d    = dm_write;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
          end
          mem_req_d = 1'b1;
          state_d   = StReq;
        end else begin
          streak_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      StReq: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (mem_rvalid) begin
          state_d = StDone;
          if (owner_q) begin
            dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end else if (!kill_d) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    // Watchdog overrides whatever REQ/RESP decided this cycle
    if (state_q == StReq || state_q == StResp) begin
      if (tmo_cnt_q == TmoLast) begin
        arb_err_d = 1'b1;
        mem_req_d = 1'b0;
        state_d   = StDone;
        if (owner_q) begin
          dm_rdata_d = '0;
          dm_valid_d = 1'b1;
        end else if (!kill_d) begin
          if_rdata_d = '0;
          if_valid_d = 1'b1;
        end else begin
          if_valid_d = 1'b0;
        end
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      kill_q      <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      arb_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

  // A flush arriving in DONE still kills the pulse already registered
  assign if_valid  = if_valid_q & ~if_flush;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_valid;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
